// File: rtl/gr_wr_burst_pack_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : gr_wr_burst_pack_fifo                                           |
// | Function : packs RATIO narrow write words into one stored word and         |
// |            releases them to a burst reader once BURST_LEN words are held.  |
// | Options  : define GR_BURST_FLUSH_EN to compile in partial-pack flush logic |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+

`ifndef MEM_WR_BL
`define MEM_WR_BL 16
`endif

module gr_wr_burst_pack_fifo #(
  parameter int IN_W      = 16,
  parameter int RATIO     = 2,
  parameter int DEPTH     = 512,
  parameter int BURST_LEN = `MEM_WR_BL,
  localparam int OUT_W    = IN_W * RATIO,
  localparam int CW       = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_vld_i,
  output logic             wr_rdy_o,
  input  logic [IN_W-1:0]  wr_data_i,
  input  logic             flush_i,
  output logic             burst_avail,
  input  logic             burst_rd_en,
  output logic [OUT_W-1:0] burst_rd_data,
  output logic             burst_rd_vld,
  output logic [CW-1:0]    rd_count,
  output logic             flush_busy,
  output logic             err_bfifo_full,
  output logic             err_bfifo_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [LW-1:0] LANE_LAST = LW'(RATIO - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] BURST_C   = CW'(BURST_LEN);

  logic [OUT_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [LW-1:0]    lane_q, lane_d;
  logic [OUT_W-1:0] pack_q, pack_d;
  logic [OUT_W-1:0] rd_data_q, rd_data_d;
  logic             rd_vld_q, rd_vld_d;
  logic             err_full_q, err_full_d;
  logic             err_empty_q, err_empty_d;

  logic             w_wr_rdy;
  logic             w_accept;
  logic             w_group_done;
  logic             w_pop;
  logic             w_mem_we;
  logic [OUT_W-1:0] w_pack_merged;
  logic [OUT_W-1:0] w_mem_wdata;
  logic             w_flush_busy;
  logic             w_flush_commit;

`ifdef GR_BURST_FLUSH_EN
  localparam logic [0:0] FL_IDLE = 1'b0;
  localparam logic [0:0] FL_BUSY = 1'b1;

  logic [0:0] fl_state_q, fl_state_d;

  always_ff @(posedge clk) begin
    if (rst) fl_state_q <= FL_IDLE;
    else     fl_state_q <= fl_state_d;
  end

  // A flush stays open until both storage and the packer have drained.
  always_comb begin
    fl_state_d = fl_state_q;
    case (fl_state_q)
      FL_IDLE: if (flush_i) fl_state_d = FL_BUSY;
      FL_BUSY: if ((count_q == '0) && (lane_q == '0)) fl_state_d = FL_IDLE;
    endcase
  end

  always_comb begin
    w_flush_busy   = (fl_state_q == FL_BUSY);
    w_flush_commit = w_flush_busy && (lane_q != '0) && (count_q < DEPTH_C);
  end
`else
  logic unused_flush_i;
  assign unused_flush_i = flush_i;

  always_comb begin
    w_flush_busy   = 1'b0;
    w_flush_commit = 1'b0;
  end
`endif

  always_comb begin
    w_wr_rdy     = (count_q < DEPTH_C) && !w_flush_commit;
    w_accept     = wr_vld_i && w_wr_rdy;
    w_group_done = w_accept && (lane_q == LANE_LAST);
    w_pop        = burst_rd_en && (count_q != '0);

    w_pack_merged = pack_q;
    for (int k = 0; k < RATIO; k++) begin
      if (lane_q == LW'(k)) w_pack_merged[k*IN_W +: IN_W] = wr_data_i;
    end

    // Upper lanes of pack_q are always zero past the fill point, so a flush
    // commit writes the register as-is.
    w_mem_we    = w_group_done || w_flush_commit;
    w_mem_wdata = w_flush_commit ? pack_q : w_pack_merged;
  end

  always_comb begin
    lane_d = lane_q;
    pack_d = pack_q;
    if (w_mem_we) begin
      lane_d = '0;
      pack_d = '0;
    end else if (w_accept) begin
      lane_d = lane_q + 1'b1;
      pack_d = w_pack_merged;
    end

    wr_ptr_d = w_mem_we ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = w_pop    ? rd_ptr_q + 1'b1 : rd_ptr_q;

    case ({w_mem_we, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    rd_vld_d  = w_pop;
    rd_data_d = w_pop ? mem_q[rd_ptr_q] : rd_data_q;

    err_full_d  = err_full_q  || (wr_vld_i && !w_wr_rdy);
    err_empty_d = err_empty_q || (burst_rd_en && (count_q == '0));
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) mem_q[wr_ptr_q] <= w_mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      lane_q      <= '0;
      pack_q      <= '0;
      rd_data_q   <= '0;
      rd_vld_q    <= 1'b0;
      err_full_q  <= 1'b0;
      err_empty_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      lane_q      <= lane_d;
      pack_q      <= pack_d;
      rd_data_q   <= rd_data_d;
      rd_vld_q    <= rd_vld_d;
      err_full_q  <= err_full_d;
      err_empty_q <= err_empty_d;
    end
  end

  always_comb begin
    wr_rdy_o        = w_wr_rdy;
    burst_avail     = (count_q >= BURST_C) || (w_flush_busy && (count_q != '0));
    burst_rd_data   = rd_data_q;
    burst_rd_vld    = rd_vld_q;
    rd_count        = count_q;
    flush_busy      = w_flush_busy;
    err_bfifo_full  = err_full_q;
    err_bfifo_empty = err_empty_q;
  end

endmodule

`default_nettype wire
